// File: rtl/ssp_uart_access_arb.sv
// Two-requester arbiter for the ssp_uart register port. Each grant runs one
// SETUP/STROBE/ACK access, then an optional idle gap before re-arbitrating.
module ssp_uart_access_arb #(
    parameter int unsigned GAP_CYCLES = 1,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        m0_req,
    input  logic        m0_wnr,
    input  logic [2:0]  m0_ra,
    input  logic [11:0] m0_di,
    output logic        m0_ack,
    output logic [11:0] m0_do,
    input  logic        m1_req,
    input  logic        m1_wnr,
    input  logic [2:0]  m1_ra,
    input  logic [11:0] m1_di,
    output logic        m1_ack,
    output logic [11:0] m1_do,
    output logic        SSP_SSEL,
    output logic [2:0]  SSP_RA,
    output logic        SSP_WnR,
    output logic [11:0] SSP_DI,
    output logic        SSP_EOC,
    input  logic [11:0] SSP_DO,
    output logic        busy,
    output logic        gnt_id
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, ACK, GAP} state_t;

    // Reload value for the gap counter; only used when the GAP state exists.
    localparam logic [3:0] GapLoad = 4'(GAP_CYCLES - 1);

    state_t      state_q;
    logic [3:0]  gapCnt_q;
    logic        lastGnt_q;
    logic        gntId_q;
    logic        busy_q;
    logic        sspSsel_q;
    logic        sspWnr_q;
    logic        sspEoc_q;
    logic [2:0]  sspRa_q;
    logic [11:0] sspDi_q;
    logic        m0Ack_q;
    logic        m1Ack_q;
    logic [11:0] m0Do_q;
    logic [11:0] m1Do_q;
    logic        winner_d;

    // A lone requester always wins; a tie goes to m0 or alternates.
    always_comb begin
        winner_d = m1_req;
        if (m0_req && m1_req) begin
            winner_d = FIXED_PRIO ? 1'b0 : ~lastGnt_q;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= IDLE;
            gapCnt_q  <= 4'd0;
            lastGnt_q <= 1'b1;
            gntId_q   <= 1'b0;
            busy_q    <= 1'b0;
            sspSsel_q <= 1'b0;
            sspWnr_q  <= 1'b0;
            sspEoc_q  <= 1'b0;
            sspRa_q   <= 3'd0;
            sspDi_q   <= 12'd0;
            m0Ack_q   <= 1'b0;
            m1Ack_q   <= 1'b0;
            m0Do_q    <= 12'd0;
            m1Do_q    <= 12'd0;
        end else begin
            m0Ack_q <= 1'b0;
            m1Ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        gntId_q   <= winner_d;
                        lastGnt_q <= winner_d;
                        sspWnr_q  <= winner_d ? m1_wnr : m0_wnr;
                        sspRa_q   <= winner_d ? m1_ra : m0_ra;
                        sspDi_q   <= winner_d ? m1_di : m0_di;
                        sspSsel_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    sspEoc_q <= 1'b1;
                    state_q  <= STROBE;
                end
                STROBE: begin
                    // SSP_WnR still holds the latched direction during STROBE.
                    if (!sspWnr_q) begin
                        if (gntId_q) m1Do_q <= SSP_DO;
                        else         m0Do_q <= SSP_DO;
                    end
                    if (gntId_q) m1Ack_q <= 1'b1;
                    else         m0Ack_q <= 1'b1;
                    sspSsel_q <= 1'b0;
                    sspWnr_q  <= 1'b0;
                    sspEoc_q  <= 1'b0;
                    state_q   <= ACK;
                end
                ACK: begin
                    if (GAP_CYCLES == 0) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        gapCnt_q <= GapLoad;
                        state_q  <= GAP;
                    end
                end
                GAP: begin
                    if (gapCnt_q == 4'd0) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        gapCnt_q <= gapCnt_q - 4'd1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m0_ack   = m0Ack_q;
    assign m1_ack   = m1Ack_q;
    assign m0_do    = m0Do_q;
    assign m1_do    = m1Do_q;
    assign SSP_SSEL = sspSsel_q;
    assign SSP_RA   = sspRa_q;
    assign SSP_WnR  = sspWnr_q;
    assign SSP_DI   = sspDi_q;
    assign SSP_EOC  = sspEoc_q;
    assign busy     = busy_q;
    assign gnt_id   = gntId_q;

endmodule

// File: tb/tb_ssp_uart_access_arb.sv
// Bench for ssp_uart_access_arb: three configurations share one stimulus stream
// and are compared each cycle against a phase-counting reference model.
module tb_ssp_uart_access_arb;

    localparam int NI = 3;

    function automatic int gapOf(int i);
        return (i == 0) ? 1 : ((i == 1) ? 3 : 0);
    endfunction

    function automatic bit fpOf(int i);
        return (i == 1);
    endfunction

    logic        Clk = 1'b0;
    logic        Rst;
    logic        req0, req1, wnr0, wnr1;
    logic [2:0]  ra0, ra1;
    logic [11:0] di0, di1;

    logic        ssSsel[NI], ssEoc[NI], ssWnr[NI], m0Ack[NI], m1Ack[NI], busy[NI], gntId[NI];
    logic [2:0]  ssRa[NI];
    logic [11:0] ssDi[NI], sdo[NI], m0Do[NI], m1Do[NI];

    logic [11:0] sspMem[NI][8];
    logic [11:0] refMem[NI][8];

    int          ph[NI];
    logic        lastG[NI], gid[NI], lwnr[NI];
    logic [2:0]  lra[NI];
    logic [11:0] ldi[NI], mdo0[NI], mdo1[NI];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int eocCnt[NI];

    always #5 Clk = ~Clk;

    for (genvar g = 0; g < NI; g++) begin : gInst
        ssp_uart_access_arb #(.GAP_CYCLES(gapOf(g)), .FIXED_PRIO(fpOf(g))) dut (
            .Clk(Clk), .Rst(Rst),
            .m0_req(req0), .m0_wnr(wnr0), .m0_ra(ra0), .m0_di(di0),
            .m0_ack(m0Ack[g]), .m0_do(m0Do[g]),
            .m1_req(req1), .m1_wnr(wnr1), .m1_ra(ra1), .m1_di(di1),
            .m1_ack(m1Ack[g]), .m1_do(m1Do[g]),
            .SSP_SSEL(ssSsel[g]), .SSP_RA(ssRa[g]), .SSP_WnR(ssWnr[g]),
            .SSP_DI(ssDi[g]), .SSP_EOC(ssEoc[g]), .SSP_DO(sdo[g]),
            .busy(busy[g]), .gnt_id(gntId[g])
        );
        assign sdo[g] = sspMem[g][ssRa[g]];
    end

    // Register file standing in for ssp_uart: writes land on a write strobe.
    always @(posedge Clk or posedge Rst) begin
        for (int i = 0; i < NI; i++) begin
            for (int j = 0; j < 8; j++) begin
                if (Rst) sspMem[i][j] <= 12'(j * 291 + 7);
                else if (ssSsel[i] && ssEoc[i] && ssWnr[i] && ssRa[i] == 3'(j)) sspMem[i][j] <= ssDi[i];
            end
        end
    end

    function automatic logic pickWinner(int i);
        if (req0 && req1) return fpOf(i) ? 1'b0 : ~lastG[i];
        return req1;
    endfunction

    // ph counts cycles since the grant: 1 setup, 2 strobe, 3 ack, 4.. gap, 0 idle.
    always @(posedge Clk or posedge Rst) begin
        for (int i = 0; i < NI; i++) begin
            if (Rst) begin
                ph[i] <= 0; lastG[i] <= 1'b1; gid[i] <= 1'b0; lwnr[i] <= 1'b0;
                lra[i] <= 3'd0; ldi[i] <= 12'd0; mdo0[i] <= 12'd0; mdo1[i] <= 12'd0;
                for (int j = 0; j < 8; j++) refMem[i][j] <= 12'(j * 291 + 7);
            end else if (ph[i] == 0) begin
                if (req0 || req1) begin
                    gid[i]   <= pickWinner(i);
                    lastG[i] <= pickWinner(i);
                    lwnr[i]  <= pickWinner(i) ? wnr1 : wnr0;
                    lra[i]   <= pickWinner(i) ? ra1 : ra0;
                    ldi[i]   <= pickWinner(i) ? di1 : di0;
                    ph[i]    <= 1;
                end
            end else if (ph[i] == 2) begin
                if (lwnr[i]) refMem[i][lra[i]] <= ldi[i];
                else if (gid[i]) mdo1[i] <= refMem[i][lra[i]];
                else mdo0[i] <= refMem[i][lra[i]];
                ph[i] <= 3;
            end else if (ph[i] == 3) begin
                ph[i] <= (gapOf(i) == 0) ? 0 : 4;
            end else begin
                ph[i] <= (ph[i] >= 3 + gapOf(i)) ? 0 : ph[i] + 1;
            end
        end
    end

    task automatic checkVal(string tag, logic [31:0] got, logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic checkOutput(string tag);
        for (int i = 0; i < NI; i++) begin
            logic        act;
            logic [16:0] expS, actS;
            logic [3:0]  expC, actC;
            act  = (ph[i] == 1) || (ph[i] == 2);
            expS = {act, lra[i], act && lwnr[i], ldi[i], ph[i] == 2};
            actS = {ssSsel[i], ssRa[i], ssWnr[i], ssDi[i], ssEoc[i]};
            expC = {ph[i] == 3 && !gid[i], ph[i] == 3 && gid[i], ph[i] != 0, gid[i]};
            actC = {m0Ack[i], m1Ack[i], busy[i], gntId[i]};
            checks += 3;
            assert (actS === expS) else begin
                errors++;
                $error("FAIL %s ssp[%0d] got %h want %h", tag, i, actS, expS);
            end
            assert (actC === expC) else begin
                errors++;
                $error("FAIL %s ackbusy[%0d] got %b want %b", tag, i, actC, expC);
            end
            assert ({m0Do[i], m1Do[i]} === {mdo0[i], mdo1[i]}) else begin
                errors++;
                $error("FAIL %s rdata[%0d] got %h/%h want %h/%h", tag, i, m0Do[i], m1Do[i], mdo0[i], mdo1[i]);
            end
        end
    endtask

    task automatic step(string tag);
        @(negedge Clk);
        checkOutput(tag);
        for (int i = 0; i < NI; i++) if (ssEoc[i] === 1'b1) eocCnt[i]++;
        cyc++;
    endtask

    task automatic applyStimulus(logic r0, logic w0, logic [2:0] a0, logic [11:0] d0,
                                 logic r1, logic w1, logic [2:0] a1, logic [11:0] d1);
        req0 = r0; wnr0 = w0; ra0 = a0; di0 = d0;
        req1 = r1; wnr1 = w1; ra1 = a1; di1 = d1;
    endtask

    task automatic pulseReset();
        Rst = 1'b1;
        step("rst_pulse");
        Rst = 1'b0;
    endtask

    initial begin
        int base[NI];
        int a0c[NI], a1c[NI];
        int lastEoc, idleRun, pulses;
        Rst = 1'b1;
        for (int i = 0; i < NI; i++) eocCnt[i] = 0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        step("reset");
        checkVal("reset_busy", busy[0], 0);
        checkVal("reset_ssel", ssSsel[0], 0);
        Rst = 1'b0;
        step("idle");

        $display("[TB] m0 write then read");
        for (int i = 0; i < NI; i++) base[i] = eocCnt[i];
        applyStimulus(1, 1, 3'd0, 12'hDED, 0, 0, 0, 0);
        step("wr"); step("wr");
        checkVal("wr_ack_early", m0Ack[0], 0);
        step("wr");
        checkVal("wr_ack_latency", m0Ack[0], 1);
        checkVal("wr_m1_quiet", m1Ack[0], 0);
        applyStimulus(0, 1, 3'd5, 12'h111, 0, 0, 0, 0);
        repeat (6) step("wr_tail");
        for (int i = 0; i < NI; i++) checkVal("wr_eoc_once", eocCnt[i] - base[i], 1);
        checkVal("wr_mem", sspMem[0][0], 12'hDED);

        applyStimulus(1, 0, 3'd0, 12'h3C3, 0, 0, 0, 0);
        step("rd"); step("rd");
        checkVal("rd_strobe", {ssEoc[0], ssWnr[0]}, 2'b10);
        step("rd");
        checkVal("rd_ack", m0Ack[0], 1);
        checkVal("rd_data", m0Do[0], 12'hDED);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (6) step("rd_tail");

        $display("[TB] simultaneous requests from reset");
        pulseReset();
        applyStimulus(1, 1, 3'd1, 12'h123, 1, 1, 3'd2, 12'h456);
        repeat (3) step("tie");
        checkVal("tie_first_m0", {m0Ack[0], m1Ack[0]}, 2'b10);
        checkVal("tie_fp_m0", {m0Ack[1], m1Ack[1]}, 2'b10);
        req0 = 1'b0;
        repeat (5) step("tie");
        checkVal("tie_second_m1", {m0Ack[0], m1Ack[0]}, 2'b01);
        req1 = 1'b0;
        repeat (6) step("tie_tail");
        checkVal("tie_mem_m1", sspMem[0][2], 12'h456);

        $display("[TB] both held continuously");
        pulseReset();
        applyStimulus(1, 1, 3'd4, 12'h0A5, 1, 0, 3'd6, 12'h5A0);
        for (int i = 0; i < NI; i++) begin a0c[i] = 0; a1c[i] = 0; end
        repeat (42) begin
            step("hold");
            for (int i = 0; i < NI; i++) begin
                if (m0Ack[i] === 1'b1) a0c[i]++;
                if (m1Ack[i] === 1'b1) a1c[i]++;
            end
        end
        checkVal("rr_balance0", (a0c[0] - a1c[0] >= -1) && (a0c[0] - a1c[0] <= 1) && a1c[0] >= 2, 1);
        checkVal("rr_balance2", (a0c[2] - a1c[2] >= -1) && (a0c[2] - a1c[2] <= 1) && a1c[2] >= 3, 1);
        checkVal("fp_m1_starved", a1c[1], 0);
        checkVal("fp_m0_served", a0c[1] >= 4, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (6) step("hold_tail");

        $display("[TB] gap spacing with m1 held");
        pulseReset();
        applyStimulus(0, 0, 0, 0, 1, 0, 3'd3, 12'h777);
        lastEoc = -1; idleRun = 0; pulses = 0;
        repeat (40) begin
            step("gap");
            if (ssEoc[1] === 1'b1) begin
                if (lastEoc >= 0) begin
                    checkVal("gap_period", cyc - lastEoc, 7);
                    checkVal("gap_idle_run", idleRun, 1);
                end
                lastEoc = cyc; idleRun = 0; pulses++;
            end else if (busy[1] === 1'b0) begin
                idleRun++;
            end
        end
        checkVal("gap_pulses", pulses >= 5, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (6) step("gap_tail");

        $display("[TB] reset during strobe");
        pulseReset();
        applyStimulus(1, 1, 3'd3, 12'hABC, 0, 0, 0, 0);
        step("mid"); step("mid");
        checkVal("mid_strobe", ssEoc[0], 1);
        #2 Rst = 1'b1;
        #1 checkOutput("rst_async");
        checkVal("rst_async_zero", {ssSsel[0], ssEoc[0], ssWnr[0], ssRa[0], ssDi[0], m0Ack[0], busy[0]}, 0);
        step("rst_hold");
        Rst = 1'b0;
        applyStimulus(1, 1, 3'd3, 12'hABC, 1, 1, 3'd7, 12'h999);
        repeat (3) step("rereq");
        checkVal("rereq_m0_wins", {m0Ack[0], m1Ack[0]}, 2'b10);
        req0 = 1'b0;
        repeat (5) step("rereq");
        req1 = 1'b0;
        repeat (6) step("rereq_tail");

        $display("[TB] randomized traffic");
        repeat (600) begin
            step("rnd");
            Rst = 1'b0;
            applyStimulus($urandom_range(0, 3) != 0, 1'($urandom), 3'($urandom), 12'($urandom),
                          $urandom_range(0, 3) != 0, 1'($urandom), 3'($urandom), 12'($urandom));
            if ($urandom_range(0, 59) == 0) begin
                #2 Rst = 1'b1;
                #1 checkOutput("rnd_rst");
            end
        end
        Rst = 1'b0;
        step("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssp_uart_access_arb.md
Name: ssp_uart_access_arb

Overview:
- Sequences and shares the ssp_uart SSP register port (SSP_SSEL/RA/WnR/DI/EOC, SSP_DO) between two requesters: m0 (host) and m1 (init/config engine).
- Arbitrates pending requests and issues exactly one SSP register access per grant, with a fixed SETUP/STROBE/ACK sequence.
- Returns read data to the granted requester and enforces a programmable idle gap between accesses.
- Sits between the requesters and ssp_uart in the same clock domain.

Parameters:
- GAP_CYCLES, 1, idle cycles inserted after each access before the next arbitration (0..15).
- FIXED_PRIO, 0, 0 = round-robin between m0/m1; 1 = m0 always wins a simultaneous request.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  m0 access request; held until m0_ack.
- m0_wnr  in  1  1 = write, 0 = read.
- m0_ra  in  3  SSP register address.
- m0_di  in  12  write data.
- m0_ack  out  1  one-cycle completion pulse.
- m0_do  out  12  read data; valid when m0_ack=1.
- m1_req, m1_wnr, m1_ra, m1_di, m1_ack, m1_do: same as m0_*.
- SSP_SSEL  out  1  SSP slave select to ssp_uart.
- SSP_RA  out  3  register address to ssp_uart.
- SSP_WnR  out  1  write/not-read to ssp_uart.
- SSP_DI  out  12  write data to ssp_uart.
- SSP_EOC  out  1  end-of-cycle strobe to ssp_uart.
- SSP_DO  in  12  read data from ssp_uart (combinational from SSP_RA).
- busy  out  1  high in every state except IDLE.
- gnt_id  out  1  granted requester (0 = m0, 1 = m1); meaningful while busy=1.

Behaviour:
- Reset (async):
  - state=IDLE; gap counter=0; last_gnt=1 (first round-robin grant goes to m0).
  - All outputs 0: SSP_*, m*_ack, m*_do, busy, gnt_id.
- All outputs are registered.
- States: IDLE, SETUP, STROBE, ACK, GAP.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that requester.
  - Both req, FIXED_PRIO=1: grant m0.
  - Both req, FIXED_PRIO=0: grant the requester opposite last_gnt.
  - On grant: latch wnr/ra/di of the winner, set gnt_id and last_gnt, go to SETUP.
- SETUP (1 cycle):
  - SSP_SSEL=1; SSP_RA, SSP_WnR, SSP_DI driven from the latched values; SSP_EOC=0.
  - Next state: STROBE.
- STROBE (1 cycle):
  - SSEL/RA/WnR/DI held; SSP_EOC=1.
  - Read: SSP_DO captured at the end of this cycle into the winner's m*_do.
  - Write: m*_do keeps its previous value.
  - Next state: ACK.
- ACK (1 cycle):
  - SSP_SSEL=0, SSP_EOC=0, SSP_WnR=0; RA/DI hold their last value.
  - Winner's m*_ack=1.
  - Next state: GAP if GAP_CYCLES>0, else IDLE.
- GAP: count GAP_CYCLES cycles, then go to IDLE. Requests are ignored during GAP.
- Latency: req seen in IDLE at edge N → SETUP at N+1, STROBE at N+2, ack visible at N+3. Back-to-back access period = 3 + GAP_CYCLES + 1 cycles.
- Requester rules:
  - Must deassert req the cycle after ack; a req still high in the IDLE cycle after GAP is treated as a new request.
  - req dropped after grant: the access still completes and ack still pulses.
  - Field changes after grant are ignored (the latched copy is used).
- The loser of a simultaneous request stays pending and is granted at the next IDLE.
- SSP_WnR=1 only during SETUP/STROBE of a write; SSP_EOC is never high for more than one cycle per access.
- Rst asserted mid-access (any state): immediate return to reset values; no ack is issued; the interrupted requester re-requests.
- GAP_CYCLES counter width is 4 bits; GAP_CYCLES=0 removes the GAP state from the path.

Test Plan:
- m0 write RA=0, DI=12'hDED; bench SSP model records → exactly one SSP_EOC pulse with SSP_SSEL=1, SSP_WnR=1, SSP_RA=0, SSP_DI=12'hDED; m0_ack 3 cycles after the request edge; m1_ack stays 0.
- m0 read RA=0 with bench SSP_DO=12'hDED → SSP_WnR=0 during STROBE; m0_do=12'hDED with m0_ack=1.
- FIXED_PRIO=0, m0 and m1 request writes (m0: RA=1, DI=12'h123; m1: RA=2, DI=12'h456) on the same cycle from reset → m0 served first, then m1; next simultaneous pair → m1 first (alternation).
- FIXED_PRIO=1, three simultaneous request pairs → m0 always granted first; m1 granted only after each m0 access.
- GAP_CYCLES=3, m1 held requesting continuously → SSP_EOC pulses exactly 7 cycles apart; busy low exactly 1 cycle between accesses.
- Rst asserted during STROBE of an m0 write → all SSP_* and acks go to 0 asynchronously; no m0_ack; m0 re-request completes normally with last_gnt reset (m0 wins the next tie under round-robin).
